// File: rtl/read_split.sv
// Burst reader: walks `count` words from `base` by STRIDE and presents each word
// (addr + MAGIC) as WORD_WIDTH/SUB_WIDTH sub-word beats over ready/valid.
module read_split #(
    parameter int WORD_WIDTH = 32,
    parameter int SUB_WIDTH  = 8,
    parameter int STRIDE     = 4,
    parameter int MAGIC      = 42069
) (
    input  logic                         _clock,
    input  logic                         _reset,
    input  logic signed [WORD_WIDTH-1:0] base,
    input  logic signed [31:0]           count,
    input  logic                         msb_first,
    input  logic                         _start,
    input  logic                         _ready,
    output logic                         _valid,
    output logic                         _done,
    output logic [SUB_WIDTH-1:0]         _out0,
    output logic [WORD_WIDTH-1:0]        _out1
);

    localparam int RATIO = WORD_WIDTH / SUB_WIDTH;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SW-1:0]         S_LAST   = SW'(RATIO - 1);
    localparam logic [WORD_WIDTH-1:0] MAGIC_W  = WORD_WIDTH'(MAGIC);
    localparam logic [WORD_WIDTH-1:0] STRIDE_W = WORD_WIDTH'(STRIDE);

    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    // Sub-word for beat s of the word at addr, honouring the slice order.
    function automatic logic [SUB_WIDTH-1:0] beat_slice(
        input logic [WORD_WIDTH-1:0] addr,
        input logic [SW-1:0]         s,
        input logic                  msb
    );
        logic [WORD_WIDTH-1:0] word;
        logic [SW-1:0]         idx;
        word = addr + MAGIC_W;
        if (msb) begin
            idx = S_LAST - s;
        end else begin
            idx = s;
        end
        word = word >> (32'(idx) * SUB_WIDTH);
        return word[SUB_WIDTH-1:0];
    endfunction

    state_t                  state_r;
    logic [WORD_WIDTH-1:0]   a_r;
    logic [31:0]             w_r;
    logic [SW-1:0]           s_r;
    logic [31:0]             cnt_r;
    logic                    msb_r;
    logic                    valid_r;
    logic                    done_r;
    logic [SUB_WIDTH-1:0]    out0_r;
    logic [WORD_WIDTH-1:0]   out1_r;

    logic [SW-1:0]           s_nx_s;
    logic [31:0]             w_nx_s;
    logic [WORD_WIDTH-1:0]   a_nx_s;
    logic [31:0]             cnt_last_s;
    logic                    last_s;
    logic                    nx_last_s;
    logic                    empty_s;
    logic                    first_last_s;

    // Position of the beat after the current one, and final-beat detection.
    always_comb begin
        cnt_last_s = cnt_r - 32'd1;
        if (s_r == S_LAST) begin
            s_nx_s = '0;
            w_nx_s = w_r + 32'd1;
            a_nx_s = a_r + STRIDE_W;
        end else begin
            s_nx_s = s_r + SW'(1);
            w_nx_s = w_r;
            a_nx_s = a_r;
        end
        last_s       = (w_r == cnt_last_s) && (s_r == S_LAST);
        nx_last_s    = (w_nx_s == cnt_last_s) && (s_nx_s == S_LAST);
        empty_s      = (count <= 32'sd0);
        first_last_s = (count == 32'sd1) && (S_LAST == SW'(0));
    end

    // Burst FSM with registered beat outputs; _start overrides any handshake.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_r <= IDLE;
            a_r     <= '0;
            w_r     <= 32'd0;
            s_r     <= '0;
            cnt_r   <= 32'd0;
            msb_r   <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b1;
            out0_r  <= '0;
            out1_r  <= '0;
        end else if (_start) begin
            a_r    <= base;
            w_r    <= 32'd0;
            s_r    <= '0;
            cnt_r  <= count;
            msb_r  <= msb_first;
            out0_r <= beat_slice(base, SW'(0), msb_first);
            out1_r <= base;
            if (empty_s) begin
                state_r <= IDLE;
                valid_r <= 1'b0;
                done_r  <= 1'b1;
            end else begin
                state_r <= EMIT;
                valid_r <= 1'b1;
                done_r  <= first_last_s;
            end
        end else begin
            case (state_r)
                EMIT: begin
                    if (_ready) begin
                        if (last_s) begin
                            state_r <= IDLE;
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            s_r     <= s_nx_s;
                            w_r     <= w_nx_s;
                            a_r     <= a_nx_s;
                            done_r  <= nx_last_s;
                            out0_r  <= beat_slice(a_nx_s, s_nx_s, msb_r);
                            out1_r  <= a_nx_s;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                IDLE: begin
                    valid_r <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    done_r  <= 1'b1;
                end
            endcase
        end
    end

    assign _valid = valid_r;
    assign _done  = done_r;
    assign _out0  = out0_r;
    assign _out1  = out1_r;

endmodule

// File: tb/tb_read_split.sv
// Self-checking bench for read_split: a table of directed bursts plus
// hand-written reset, restart and mid-burst reset sequences.
module tb_read_split;

    logic        _clock = 1'b0;
    logic        _reset;
    logic [31:0] base;
    logic [31:0] count;
    logic        msb_first;
    logic        _start;
    logic        _ready;
    logic        _valid;
    logic        _done;
    logic [7:0]  _out0;
    logic [31:0] _out1;

    int n_checks = 0;
    int n_fail   = 0;

    read_split dut (
        ._clock    (_clock),
        ._reset    (_reset),
        .base      (base),
        .count     (count),
        .msb_first (msb_first),
        ._start    (_start),
        ._ready    (_ready),
        ._valid    (_valid),
        ._done     (_done),
        ._out0     (_out0),
        ._out1     (_out1)
    );

    always #5 _clock = ~_clock;

    // exp0: byte k = beat k; exp1: 32-bit slot j = address of word j
    typedef struct {
        logic [31:0] base;
        int          count;
        logic        msb;
        logic        stall;
        int          nbeats;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge _clock);
        #1;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int got;
        int cyc;
        base      = v.base;
        count     = v.count;
        msb_first = v.msb;
        _start    = 1'b1;
        _ready    = 1'b0;
        tick();
        _start = 1'b0;
        got = 0;
        cyc = 0;
        if (v.nbeats == 0) begin
            check($sformatf("v%0d empty valid", id), 32'(_valid), 32'd0);
            check($sformatf("v%0d empty done", id), 32'(_done), 32'd1);
            _ready = 1'b1;
            repeat (3) begin
                tick();
                check($sformatf("v%0d empty stays idle", id), 32'(_valid), 32'd0);
            end
        end else begin
            while (got < v.nbeats && cyc < 64) begin
                check($sformatf("v%0d b%0d valid", id, got), 32'(_valid), 32'd1);
                check($sformatf("v%0d b%0d out0", id, got), 32'(_out0), 32'(v.exp0[8*got +: 8]));
                check($sformatf("v%0d b%0d out1", id, got), _out1, v.exp1[32*(got/4) +: 32]);
                check($sformatf("v%0d b%0d done", id, got), 32'(_done), 32'(got == v.nbeats - 1));
                _ready = v.stall ? cyc[0] : 1'b1;
                tick();
                if (_ready) got++;
                cyc++;
            end
            check($sformatf("v%0d beats accepted", id), 32'(got), 32'(v.nbeats));
            if (!v.stall) check($sformatf("v%0d burst cycles", id), 32'(cyc), 32'(v.nbeats));
            check($sformatf("v%0d valid after burst", id), 32'(_valid), 32'd0);
            check($sformatf("v%0d done after burst", id), 32'(_done), 32'd1);
        end
    endtask

    initial begin
        // MAGIC = 0xA455
        vecs[0] = '{32'h0000_0000, 1, 1'b0, 1'b0, 4, 64'h0000_0000_0000_A455, 64'h0};
        vecs[1] = '{32'h0000_0000, 1, 1'b1, 1'b0, 4, 64'h0000_0000_55A4_0000, 64'h0};
        vecs[2] = '{32'h0000_0004, 2, 1'b0, 1'b1, 8, 64'h0000_A45D_0000_A459, 64'h0000_0008_0000_0004};
        vecs[3] = '{32'hFFFF_FFFC, 2, 1'b0, 1'b0, 8, 64'h0000_A455_0000_A451, 64'h0000_0000_FFFF_FFFC};
        vecs[4] = '{32'h0000_0100, 1, 1'b1, 1'b0, 4, 64'h0000_0000_55A5_0000, 64'h0000_0000_0000_0100};
        vecs[5] = '{32'h0000_0010, 0, 1'b0, 1'b0, 0, 64'h0, 64'h0};
        vecs[6] = '{32'h0000_0010, -3, 1'b0, 1'b0, 0, 64'h0, 64'h0};

        _reset    = 1'b0;
        base      = 32'd0;
        count     = 32'd0;
        msb_first = 1'b0;
        _start    = 1'b0;
        _ready    = 1'b0;
        tick();
        check("reset valid", 32'(_valid), 32'd0);
        check("reset done", 32'(_done), 32'd1);
        check("reset out0", 32'(_out0), 32'd0);
        check("reset out1", _out1, 32'd0);
        tick();
        _reset = 1'b1;

        // ready toggling in idle has no effect
        for (int i = 0; i < 4; i++) begin
            _ready = i[0];
            tick();
            check("idle valid", 32'(_valid), 32'd0);
            check("idle done", 32'(_done), 32'd1);
            check("idle out0", 32'(_out0), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // restart during beat 2 of a 3-word burst
        base = 32'd0; count = 32'd3; msb_first = 1'b0; _start = 1'b1; _ready = 1'b1;
        tick();
        _start = 1'b0;
        check("rs beat0", 32'(_out0), 32'h55);
        tick();
        check("rs beat1", 32'(_out0), 32'hA4);
        tick();
        check("rs beat2 valid", 32'(_valid), 32'd1);
        base = 32'h100; count = 32'd1; _start = 1'b1;
        tick();
        _start = 1'b0;
        check("rs new valid", 32'(_valid), 32'd1);
        check("rs new out0", 32'(_out0), 32'h55);
        check("rs new out1", _out1, 32'h100);
        check("rs new done", 32'(_done), 32'd0);
        tick();
        check("rs new beat1", 32'(_out0), 32'hA5);
        repeat (3) tick();
        check("rs end valid", 32'(_valid), 32'd0);
        check("rs end done", 32'(_done), 32'd1);

        // asynchronous reset mid-burst
        base = 32'd0; count = 32'd3; msb_first = 1'b0; _start = 1'b1; _ready = 1'b1;
        tick();
        _start = 1'b0;
        tick();
        check("mr pre valid", 32'(_valid), 32'd1);
        _reset = 1'b0;
        #1;
        check("mr async valid", 32'(_valid), 32'd0);
        check("mr async done", 32'(_done), 32'd1);
        check("mr async out0", 32'(_out0), 32'd0);
        tick();
        _reset = 1'b1;
        repeat (4) begin
            tick();
            check("mr no beats", 32'(_valid), 32'd0);
            check("mr done", 32'(_done), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
